alu_seq: RTL and testbench

Parametrised, registered successor to the lab datapath's combinational 16-bit ALU. It adds a 3-bit opcode, a registered result, a full status-flag set (Z, N, C, V), and an iterative multi-cycle multiply. A start/ready/done handshake lets the controller FSM issue single-cycle ops back-to-back and stall on multiply. It sits between the register-file read operands and the writeback mux.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_core.sv | 60 ++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types for the sequential ALU: opcodes, FSM states
//                and the status-flag bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_OP_W = 3;

    typedef enum logic [c_OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    // Field order gives {z, n, c, v} when the struct is viewed as a vector.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_core
//  Description : Combinational single-cycle datapath (ADD..SHL) with Z/N/C/V
//                flag generation. MUL is handled iteratively by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_op_t           i_op,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_res,
    output alu_flags_t        o_flags
);

    localparam int c_SHW = $clog2(WIDTH);
    localparam int c_MSB = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_c;
    logic           w_v;

    // One extra bit captures carry-out; for subtraction it is the borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Result and carry/overflow selection by opcode.
    always_comb begin
        o_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
            end
            OP_SUB: begin
                o_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);
            end
            OP_AND: o_res = i_a & i_b;
            OP_NOT: o_res = ~i_b;
            OP_OR:  o_res = i_a | i_b;
            OP_XOR: o_res = i_a ^ i_b;
            OP_SHL: o_res = i_a << i_b[c_SHW-1:0];
            default: o_res = '0;
        endcase
    end

    assign o_flags = {(o_res == '0), o_res[c_MSB], w_c, w_v};

endmodule : alu_seq_core
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with start/ready/done handshake. Single-cycle
//                ops complete in one clock; MUL runs a WIDTH-step
//                shift-and-add loop. Result and flags are held until the
//                next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  Ain,
    input  logic [WIDTH-1:0]  Bin,
    output logic              ready,
    output logic              done,
    output logic [WIDTH-1:0]  out,
    output logic              Z,
    output logic              N,
    output logic              C,
    output logic              V
);

    localparam int               c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic             w_accept_alu;
    logic             w_accept_mul;
    logic             w_mul_last;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    alu_flags_t       w_mul_flags;

    logic [WIDTH-1:0] r_out;
    alu_flags_t       r_flags;
    logic             r_done;

    logic [WIDTH-1:0] w_core_res;
    alu_flags_t       w_core_flags;

    alu_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op    (alu_op_t'(op)),
        .i_a     (Ain),
        .i_b     (Bin),
        .o_res   (w_core_res),
        .o_flags (w_core_flags)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and acceptance decode; starts outside IDLE are dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept_alu = 1'b0;
        w_accept_mul = 1'b0;
        w_mul_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        w_accept_mul = 1'b1;
                        w_state_nxt  = ST_MUL;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Partial product for the current multiplier bit folded into the sum.
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_flags = {(w_acc_next == '0), w_acc_next[WIDTH-1], 2'b00};

    // Multiply shift/accumulate registers plus result/flag/done registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept_alu) begin
                r_out   <= w_core_res;
                r_flags <= w_core_flags;
                r_done  <= 1'b1;
            end
            if (w_accept_mul) begin
                r_mcand  <= Ain;
                r_mplier <= Bin;
                r_acc    <= '0;
                r_cnt    <= c_CNT_INIT;
            end
            if (r_state == ST_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - c_CNT_ONE;
            end
            if (w_mul_last) begin
                r_out   <= w_acc_next;
                r_flags <= w_mul_flags;
                r_done  <= 1'b1;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = r_done;
    assign out   = r_out;
    assign Z     = r_flags.z;
    assign N     = r_flags.n;
    assign C     = r_flags.c;
    assign V     = r_flags.v;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq (WIDTH=16): directed scenarios
//                followed by randomized traffic against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic        ready;
    logic        done;
    logic [15:0] out;
    logic        Z, N, C, V;

    int          checks;
    int          errors;
    exp_t        q[$];
    logic [15:0] cur_out;
    logic [3:0]  cur_flags;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .Ain     (Ain),
        .Bin     (Bin),
        .ready   (ready),
        .done    (done),
        .out     (out),
        .Z       (Z),
        .N       (N),
        .C       (C),
        .V       (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input bit [2:0] o, input bit [15:0] a, input bit [15:0] b);
        exp_t   e;
        longint ua;
        longint ub;
        longint r;
        int     sa;
        int     sb;
        int     s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        r = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            3'd0: begin
                r = ua + ub;
                e.c = (r > 65535);
                s = sa + sb;
                e.v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = ua - ub + 65536;
                e.c = (ua >= ub);
                s = sa - sb;
                e.v = (s > 32767) || (s < -32768);
            end
            3'd2: r = ua & ub;
            3'd3: r = (~ub) & 65535;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = ua << (ub % 16);
            default: r = ua * ub;
        endcase
        e.out = r[15:0];
        e.z = (e.out == 16'h0000);
        e.n = e.out[15];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_out", {16'h0, out}, {16'h0, e.out});
                chk("result_flags", {28'h0, Z, N, C, V}, {28'h0, e.z, e.n, e.c, e.v});
                cur_out   = e.out;
                cur_flags = {e.z, e.n, e.c, e.v};
            end
        end
    end

    // Called at a negedge; presents one start for one edge.
    task automatic send(input bit [2:0] o, input bit [15:0] a, input bit [15:0] b, input bit expect_done);
        start = 1'b1;
        op    = o;
        Ain   = a;
        Bin   = b;
        @(posedge clk);
        if (expect_done) q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the WIDTH busy cycles of a multiply; optionally pokes a start.
    task automatic mul_busy(input int poke_at);
        for (int k = 0; k < WIDTH; k++) begin
            chk("mul_ready_low", {31'h0, ready}, 32'h0);
            chk("mul_out_held", {16'h0, out}, {16'h0, cur_out});
            if (k == poke_at) begin
                start = 1'b1;
                op    = 3'd0;
                Ain   = 16'h0001;
                Bin   = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("mul_ready_back", {31'h0, ready}, 32'h1);
        chk("mul_done", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0]  o;
        bit [15:0] a;
        bit [15:0] b;
        checks    = 0;
        errors    = 0;
        cur_out   = 16'h0;
        cur_flags = 4'h0;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        Ain       = 16'h0;
        Bin       = 16'h0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset_out", {16'h0, out}, 32'h0);
        chk("reset_flags", {28'h0, Z, N, C, V}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_ready", {31'h0, ready}, 32'h1);

        // Signed overflow on ADD.
        send(3'd0, 16'h7FFF, 16'h0001, 1'b1);
        chk("add_ovf_done", {31'h0, done}, 32'h1);
        chk("add_ovf_out", {16'h0, out}, 32'h8000);
        chk("add_ovf_flags", {28'h0, Z, N, C, V}, 32'b0101);
        @(negedge clk);
        chk("done_single_pulse", {31'h0, done}, 32'h0);

        // Equal-operand SUB then carry-out ADD.
        send(3'd1, 16'h0005, 16'h0005, 1'b1);
        chk("sub_eq_flags", {28'h0, Z, N, C, V}, 32'b1010);
        send(3'd0, 16'hFFFF, 16'h0001, 1'b1);
        chk("add_carry_flags", {28'h0, Z, N, C, V}, 32'b1010);
        @(negedge clk);

        // Back-to-back single-cycle ops.
        send(3'd2, 16'hF0F0, 16'h0FF0, 1'b1);
        chk("b2b_done0", {31'h0, done}, 32'h1);
        chk("b2b_out0", {16'h0, out}, 32'h00F0);
        chk("b2b_ready0", {31'h0, ready}, 32'h1);
        send(3'd5, 16'hFFFF, 16'h00FF, 1'b1);
        chk("b2b_done1", {31'h0, done}, 32'h1);
        chk("b2b_out1", {16'h0, out}, 32'hFF00);
        chk("b2b_ready1", {31'h0, ready}, 32'h1);
        send(3'd3, 16'h1234, 16'h00FF, 1'b1);
        chk("b2b_done2", {31'h0, done}, 32'h1);
        chk("b2b_out2", {16'h0, out}, 32'hFF00);
        @(negedge clk);
        chk("b2b_done_end", {31'h0, done}, 32'h0);

        // Multiply with an ignored start in the middle.
        send(3'd7, 16'h0012, 16'h0034, 1'b1);
        mul_busy(5);
        chk("mul_out", {16'h0, out}, 32'h03A8);
        @(negedge clk);
        chk("mul_no_extra_done", {31'h0, done}, 32'h0);
        chk("mul_out_kept", {16'h0, out}, 32'h03A8);

        // Reset in the middle of a multiply aborts it.
        send(3'd7, 16'h00FF, 16'h0101, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        cur_out   = 16'h0;
        cur_flags = 4'h0;
        chk("abort_out", {16'h0, out}, 32'h0);
        chk("abort_flags", {28'h0, Z, N, C, V}, 32'h0);
        chk("abort_ready", {31'h0, ready}, 32'h1);
        repeat (WIDTH) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, done}, 32'h0);
        end
        send(3'd6, 16'h0001, 16'h0004, 1'b1);
        chk("shl_out", {16'h0, out}, 32'h0010);
        @(negedge clk);

        // Randomized traffic, corner operands mixed in.
        for (int i = 0; i < 300; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'hFFFF;
                2: a = 16'h7FFF;
                3: a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: b = 16'h0001;
                3: b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            send(o, a, b, 1'b1);
            if (o == 3'd7) begin
                mul_busy(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
